sort_result_streamer: RTL
=========================

SORT_RESULT_STREAMER -- requirements
Module: sort_result_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning bit width of one sorted word.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of words per sort result (sorter array depth, >=2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-005 SHALL have port done, input, 1, meaning the sorter completion level; the sorter's data_out is valid while it is high.
REQ-006 SHALL have port data_out, input, DEPTH x WIDTH unpacked array, meaning the sorter's sorted result.
REQ-007 SHALL have port m_valid, output, 1, meaning the stream word is valid.
REQ-008 SHALL have port m_ready, input, 1, meaning the consumer accepts the word.
REQ-009 SHALL have port m_data, output, WIDTH, meaning the stream word.
REQ-010 SHALL have port m_last, output, 1, meaning the current word is index DEPTH-1.
REQ-011 SHALL have port busy, output, 1, meaning the block is high in any state other than IDLE.
REQ-012 SHALL have port stream_done, output, 1, meaning a one-cycle pulse after the last word is transferred.
REQ-013 SHALL have port overrun, output, 1, meaning a sticky flag for a done rising edge seen while busy.
REQ-014 SHALL have port order_err, output, 1, meaning a sticky flag for a non-ascending word pair (see Configuration).

Function
REQ-015 SHALL register done as done_d and detect a rising edge as done && !done_d.
REQ-016 SHALL implement the states IDLE, STREAM and FIN.
REQ-017 In IDLE, on a done rising edge, SHALL capture all DEPTH words of data_out into an internal buffer, set idx=0 and go to STREAM on the same edge.
REQ-018 SHALL give latency of exactly one cycle: m_valid is high in the cycle after the capture edge.
REQ-019 In STREAM, SHALL drive m_valid=1, m_data=buf[idx] and m_last=(idx==DEPTH-1).
REQ-020 In STREAM, m_data SHALL hold stable while m_valid && !m_ready.
REQ-021 SHALL define a transfer as the clock edge where m_valid && m_ready, which increments idx; idx SHALL never wrap.
REQ-022 A transfer with m_last=1 SHALL move the block to FIN.
REQ-023 FIN SHALL last exactly one cycle with stream_done=1 and m_valid=0, then return to IDLE.
REQ-024 A done rising edge in STREAM or FIN SHALL be ignored for capture and SHALL set overrun.
REQ-025 A done that is still high after returning to IDLE SHALL NOT re-trigger; only a new rising edge triggers a capture.
REQ-026 m_valid SHALL be 0 in IDLE and FIN, regardless of m_ready.
REQ-027 The captured buffer SHALL be immune to data_out changes after the capture edge.

Reset
REQ-028 On rst_n=0, SHALL asynchronously force state=IDLE, idx=0 and done_d=0.
REQ-029 On rst_n=0, SHALL asynchronously force m_valid, m_last, busy, stream_done, overrun and order_err to 0, and m_data to 0.
REQ-030 Reset mid-stream SHALL abort the stream without a stream_done pulse; the buffer contents are don't-care.

Configuration
REQ-031 With SORT_CHECK_EN defined, SHALL compare each transferred word after index 0 to the previously transferred word, unsigned, and set order_err when word < previous.
REQ-032 With SORT_CHECK_EN defined, order_err SHALL clear on each new capture and otherwise stay sticky until reset.
REQ-033 With SORT_CHECK_EN undefined, order_err SHALL be tied to 0 and no comparator logic SHALL exist.

Structure
REQ-034 Package sort_pkg SHALL hold the default WIDTH/DEPTH localparams and the streamer state enum typedef, shared with bubble_sort and its bench.
REQ-035 The order checker SHALL be a sub-module sort_order_check, instantiated only under SORT_CHECK_EN.

Verification
REQ-036 Scenario: data_out=0..15, done rises, m_ready=1 constantly -> m_valid rises 1 cycle later, 16 transfers of 0..15 on consecutive cycles, m_last on value 15, stream_done pulses once, order_err=0.
REQ-037 Scenario: same data, m_ready toggling 1,0,1,0 -> m_data holds during stalls, 16 transfers in 32 cycles, no word lost or duplicated.
REQ-038 Scenario: second done rising edge at transfer 5 -> overrun=1, stream continues with the original data to index 15, no recapture.
REQ-039 Scenario (SORT_CHECK_EN): data_out={1,2,9,3,...} -> order_err=1 after the 4th transfer, cleared on the next capture.
REQ-040 Scenario: rst_n low at transfer 7 -> all outputs 0 immediately, no stream_done, a subsequent done edge starts a fresh stream at index 0.
REQ-041 Scenario: done held high for 100 cycles -> exactly one stream is produced.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared defaults and the streamer state encoding for the sorter, its
// result streamer and their benches.
package sort_pkg;

  localparam int unsigned SORT_WIDTH = 32;
  localparam int unsigned SORT_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FIN    = 2'd2
  } stream_state_e;

endpackage

// File: rtl/sort_result_streamer_if.sv
// Valid/ready word stream carrying the sorted result out of the streamer.
interface sort_result_streamer_if
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH = SORT_WIDTH
);

  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/sort_order_check.sv
// Flags a transferred word that is smaller (unsigned) than the word transferred
// just before it; the flag clears on each new capture and is otherwise sticky.
module sort_order_check #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             xfer,
  input  logic             first,
  input  logic [WIDTH-1:0] word,
  output logic             order_err
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic             err_q, err_d;

  always_comb begin
    prev_d = prev_q;
    err_d  = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if (xfer) begin
      prev_d = word;
      if (!first && (word < prev_q)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

  assign order_err = err_q;

endmodule

// File: rtl/sort_result_streamer.sv
// Captures a completed sort result on the rising edge of done and streams it
// word by word over a valid/ready interface. Define SORT_CHECK_EN for order checking.
module sort_result_streamer
  import sort_pkg::*;
#(
  parameter int unsigned WIDTH = SORT_WIDTH,
  parameter int unsigned DEPTH = SORT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  done,
  input  logic [WIDTH-1:0]      data_out [DEPTH],
  sort_result_streamer_if.master m,
  output logic                  busy,
  output logic                  stream_done,
  output logic                  overrun,
  output logic                  order_err
);

  localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  stream_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_d_q;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] word_buf_q [DEPTH];
  logic [WIDTH-1:0] word_buf_d [DEPTH];

  logic rise, capture, xfer, is_last;

  assign rise    = done && !done_d_q;
  assign capture = rise && (state_q == ST_IDLE);
  assign xfer    = m.m_valid && m.m_ready;
  assign is_last = (idx_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    // A new result arriving while the previous one is still streaming is dropped.
    overrun_d  = overrun_q || (rise && (state_q != ST_IDLE));
    word_buf_d = word_buf_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d    = ST_STREAM;
          idx_d      = '0;
          word_buf_d = data_out;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          if (is_last) state_d = ST_FIN;
          else         idx_d   = idx_q + 1'b1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      done_d_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_d_q  <= done;
      overrun_q <= overrun_d;
    end
  end

  // Buffer contents are irrelevant after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    word_buf_q <= word_buf_d;
  end

  assign m.m_valid   = (state_q == ST_STREAM);
  assign m.m_data    = (state_q == ST_STREAM) ? word_buf_q[idx_q] : '0;
  assign m.m_last    = (state_q == ST_STREAM) && is_last;
  assign busy        = (state_q != ST_IDLE);
  assign stream_done = (state_q == ST_FIN);
  assign overrun     = overrun_q;

`ifdef SORT_CHECK_EN
  sort_order_check #(
    .WIDTH(WIDTH)
  ) u_order_check (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (capture),
    .xfer     (xfer),
    .first    (idx_q == '0),
    .word     (m.m_data),
    .order_err(order_err)
  );
`else
  assign order_err = 1'b0;
`endif

endmodule
